uart_tx_arbiter: RTL and testbench

- Round-robin scheduler that shares one UART byte transmitter among NUM_REQ requesters.
- Each requester offers a byte through a valid/ready handshake. The block captures the winner's byte, pulses the transmitter's transmit strobe and waits for frame completion before granting again.
- A watchdog recovers the block if the transmitter never reports completion.
- Sits between on-chip byte producers (CPU MMIO, debug port) and the TxD transmitter (50 MHz clock, 5208 clocks/bit).

---
 rtl/uart_tx_arbiter.sv | 141 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART byte transmitter among NUM_REQ requesters.
// Each grant captures one byte, pulses tx_transmit, then waits for a rising edge
// of tx_done; a watchdog returns to idle if the transmitter never finishes.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned ID_W           = 2,
  parameter int unsigned TIMEOUT_CYCLES = 62500,
  parameter int unsigned CNT_W          = 20
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_transmit,
  input  logic                 tx_done,
  output logic [ID_W-1:0]      grant_id,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StGrant  = 2'd1;
  localparam logic [1:0] StLaunch = 2'd2;
  localparam logic [1:0] StBusy   = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [ID_W-1:0] grant_id_q, grant_id_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            timeout_err_q, timeout_err_d;
  logic            tx_done_q;

  logic            win_found;
  logic [ID_W-1:0] win_idx;
  logic [ID_W-1:0] cand;
  logic [7:0]      sel_byte;
  logic            done_rise;

  // Accepts both pulse-style and level-until-next-start done flags.
  assign done_rise = tx_done & ~tx_done_q;

  // Round-robin scan: first valid requester at or above the pointer, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = ID_W'((32'(ptr_q) + k) % NUM_REQ);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Byte offered by the currently granted requester.
  always_comb begin
    sel_byte = 8'h00;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_id_q == ID_W'(i)) begin
        sel_byte = req_data[8*i +: 8];
      end
    end
  end

  // Next-state logic for the grant / launch / busy sequence and watchdog.
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    grant_id_d    = grant_id_q;
    tx_data_d     = tx_data_q;
    cnt_d         = cnt_q;
    timeout_err_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (win_found) begin
          grant_id_d = win_idx;
          state_d    = StGrant;
        end
      end
      StGrant: begin
        if (req_valid[grant_id_q]) begin
          tx_data_d = sel_byte;
          ptr_d     = (grant_id_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;
          state_d   = StLaunch;
        end else begin
          // Requester withdrew its offer: drop the grant, keep the pointer.
          state_d = StIdle;
        end
      end
      StLaunch: begin
        cnt_d   = '0;
        state_d = StBusy;
      end
      StBusy: begin
        // Completion takes priority over a coincident timeout.
        if (done_rise) begin
          state_d = StIdle;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          timeout_err_d = 1'b1;
          state_d       = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      ptr_q         <= '0;
      grant_id_q    <= '0;
      tx_data_q     <= 8'h00;
      cnt_q         <= '0;
      timeout_err_q <= 1'b0;
      tx_done_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      grant_id_q    <= grant_id_d;
      tx_data_q     <= tx_data_d;
      cnt_q         <= cnt_d;
      timeout_err_q <= timeout_err_d;
      tx_done_q     <= tx_done;
    end
  end

  assign req_ready   = (state_q == StGrant) ? (NUM_REQ'(1) << grant_id_q) : '0;
  assign tx_transmit = (state_q == StLaunch);
  assign busy        = (state_q != StIdle);
  assign tx_data     = tx_data_q;
  assign grant_id    = grant_id_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: a transaction-timeline model predicts
// every output each cycle; directed scenarios add literal checks on frame order,
// latencies and reset behaviour.
module tb_uart_tx_arbiter;

  localparam int unsigned NR    = 4;
  localparam int unsigned IDW   = 2;
  localparam int unsigned T     = 300;
  localparam int unsigned CW    = 20;
  localparam int unsigned FRAME = 120;

  logic            clk = 1'b0;
  logic            reset;
  logic [NR-1:0]   req_valid;
  logic [8*NR-1:0] req_data;
  logic [NR-1:0]   req_ready;
  logic [7:0]      tx_data;
  logic            tx_transmit;
  logic            tx_done;
  logic [IDW-1:0]  grant_id;
  logic            busy;
  logic            timeout_err;

  uart_tx_arbiter #(
    .NUM_REQ(NR), .ID_W(IDW), .TIMEOUT_CYCLES(T), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tx_data(tx_data), .tx_transmit(tx_transmit),
    .tx_done(tx_done), .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int ncyc  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, ncyc);
    end
  endtask

  // ---------------- model: one transaction timeline -----------------
  // A grant decided at edge m_s shows ready in the following cycle, transmit one
  // cycle later, and ends on a done rising edge or at edge m_s+2+T.
  int             cyc = 0;
  bit             m_live = 0;
  bit             m_act = 0;
  int             m_s = 0;
  logic [IDW-1:0] m_gid = '0;
  int unsigned    m_ptr = 0;
  logic [7:0]     m_data = 8'h00;
  bit             m_err = 0;
  bit             m_done_prev = 0;

  always @(posedge clk) begin
    bit found;
    bit rise;
    int unsigned j;
    rise = tx_done && !m_done_prev;
    m_done_prev = tx_done;
    cyc++;
    m_err = 0;
    if (reset) begin
      m_live = 1; m_act = 0; m_ptr = 0; m_gid = '0; m_data = 8'h00; m_done_prev = 0;
    end else if (!m_act) begin
      found = 0;
      for (int unsigned k = 0; k < NR; k++) begin
        j = (m_ptr + k) % NR;
        if (!found && req_valid[IDW'(j)]) begin
          found = 1; m_act = 1; m_s = cyc; m_gid = IDW'(j);
        end
      end
    end else if (cyc == m_s + 1) begin
      if (req_valid[m_gid]) begin
        m_data = 8'(req_data >> (8 * int'(m_gid)));
        m_ptr  = (int'(m_gid) + 1) % NR;
      end else begin
        m_act = 0;
      end
    end else if (cyc >= m_s + 3) begin
      if (rise) m_act = 0;
      else if (cyc == m_s + 2 + int'(T)) begin
        m_err = 1; m_act = 0;
      end
    end
  end

  // Compare every cycle once the model has seen reset.
  always @(negedge clk) begin
    logic [NR-1:0] e_ready;
    if (m_live) begin
      e_ready = (m_act && cyc == m_s) ? (NR'(1) << m_gid) : '0;
      chk("m_req_ready", 32'(req_ready), 32'(e_ready));
      chk("m_tx_transmit", 32'(tx_transmit), 32'(m_act && cyc == m_s + 1));
      chk("m_busy", 32'(busy), 32'(m_act));
      chk("m_grant_id", 32'(grant_id), 32'(m_gid));
      chk("m_tx_data", 32'(tx_data), 32'(m_data));
      chk("m_timeout_err", 32'(timeout_err), 32'(m_err));
    end
  end

  // ---------------- monitor: transmitted bytes and error pulses ----
  logic [7:0] sent_q[$];
  int tx_cyc = 0;
  int err_cyc = 0;
  int err_cnt = 0;

  always @(negedge clk) begin
    ncyc++;
    if (tx_transmit === 1'b1) begin
      sent_q.push_back(tx_data);
      tx_cyc = ncyc;
    end
    if (timeout_err === 1'b1) begin
      err_cnt++;
      err_cyc = ncyc;
    end
  end

  // ---------------- stimulus helpers --------------------------------
  logic [NR-1:0] acc_pend;
  logic [NR-1:0] withdraw;
  int            cd;
  int            done_mode;  // 0 pulse, 1 hold until next start, 2 never

  // One cycle: requesters drop valid after acceptance; transmitter model runs.
  task automatic step();
    @(negedge clk);
    for (int i = 0; i < int'(NR); i++) begin
      if (acc_pend[i]) begin
        req_valid[i] = 1'b0;
        acc_pend[i]  = 1'b0;
      end
    end
    for (int i = 0; i < int'(NR); i++) begin
      if (req_ready[i] && req_valid[i]) begin
        if (withdraw[i]) req_valid[i] = 1'b0;
        else acc_pend[i] = 1'b1;
      end
    end
    if (done_mode == 0 && tx_done) tx_done = 1'b0;
    if (cd > 0) begin
      cd--;
      if (cd == 0) tx_done = 1'b1;
    end
    if (tx_transmit === 1'b1 && done_mode != 2) begin
      cd = FRAME;
      if (done_mode == 1) tx_done = 1'b0;
    end
  endtask

  task automatic do_reset(input int n, input bit rnd);
    step();
    reset = 1'b1; cd = 0; tx_done = 1'b0; acc_pend = '0;
    repeat (n) begin
      step();
      if (rnd) req_valid = NR'($urandom);
      chk("rst_req_ready", 32'(req_ready), 32'h0);
      chk("rst_tx_transmit", 32'(tx_transmit), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
    end
    reset = 1'b0;
    if (rnd) req_valid = '0;
  endtask

  task automatic wait_sent(input int n);
    int k = 0;
    while (sent_q.size() < n && k < 3000) begin
      step();
      k++;
    end
    chk("wait_sent", 32'(sent_q.size() >= n), 32'h1);
  endtask

  task automatic wait_idle();
    int k = 0;
    step();
    while (busy !== 1'b0 && k < 3000) begin
      step();
      k++;
    end
    chk("wait_idle", 32'(busy), 32'h0);
    repeat (2) step();
  endtask

  // ---------------- directed scenarios ------------------------------
  initial begin
    int base;
    int t0;
    int k;
    logic [7:0] exp_rr[7];
    exp_rr[0] = 8'h11; exp_rr[1] = 8'h22; exp_rr[2] = 8'h33; exp_rr[3] = 8'h44;
    exp_rr[4] = 8'h55; exp_rr[5] = 8'h77; exp_rr[6] = 8'h66;

    reset = 1'b1; req_valid = '0; req_data = '0; tx_done = 1'b0;
    acc_pend = '0; withdraw = '0; cd = 0; done_mode = 0;

    // Reset with random offers, then one idle cycle after release.
    do_reset(5, 1'b1);
    step();
    chk("rel_req_ready", 32'(req_ready), 32'h0);
    chk("rel_busy", 32'(busy), 32'h0);
    chk("rel_grant_id", 32'(grant_id), 32'h0);
    chk("rel_timeout_err", 32'(timeout_err), 32'h0);
    chk("rel_tx_data", 32'(tx_data), 32'h0);

    // Single requester 2.
    req_data[23:16] = 8'h5A; req_valid[2] = 1'b1;
    step();
    chk("single_ready", 32'(req_ready), 32'h4);
    chk("single_no_tx_yet", 32'(tx_transmit), 32'h0);
    step();
    chk("single_ready_off", 32'(req_ready), 32'h0);
    chk("single_tx", 32'(tx_transmit), 32'h1);
    chk("single_tx_data", 32'(tx_data), 32'h5A);
    step();
    chk("single_tx_off", 32'(tx_transmit), 32'h0);
    chk("single_busy", 32'(busy), 32'h1);
    k = 0;
    while (tx_done !== 1'b1 && k < int'(FRAME) + 10) begin
      step();
      k++;
    end
    step();
    chk("single_busy_fall", 32'(busy), 32'h0);
    chk("single_no_err", 32'(err_cnt), 32'h0);
    chk("single_grant_id", 32'(grant_id), 32'h2);

    // Round robin with level-style done flag.
    do_reset(2, 1'b0);
    done_mode = 1;
    base = sent_q.size();
    req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    req_valid = 4'b1111;
    wait_sent(base + 4);
    req_data[7:0] = 8'h55; req_valid[0] = 1'b1;
    wait_sent(base + 5);
    req_data[7:0] = 8'h66; req_data[23:16] = 8'h77;
    req_valid[0] = 1'b1; req_valid[2] = 1'b1;
    wait_sent(base + 7);
    wait_idle();
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("rr_order_%0d", i),
          32'((sent_q.size() > base + i) ? sent_q[base + i] : 8'hxx), 32'(exp_rr[i]));
    end

    // Watchdog: first frame never completes, pending requester 3 still served.
    do_reset(2, 1'b0);
    done_mode = 2;
    base = sent_q.size();
    t0 = err_cnt;
    req_data[15:8] = 8'hB1; req_data[31:24] = 8'hB3; req_valid = 4'b1010;
    wait_sent(base + 1);
    k = tx_cyc;
    while (err_cnt == t0 && ncyc < k + int'(T) + 20) step();
    done_mode = 0;
    chk("wd_latency", 32'(err_cyc - k), 32'(T + 1));
    wait_sent(base + 2);
    wait_idle();
    chk("wd_err_once", 32'(err_cnt - t0), 32'h1);
    chk("wd_next_byte", 32'((sent_q.size() > base + 1) ? sent_q[base + 1] : 8'hxx), 32'hB3);

    // Reset 100 cycles into a frame; pointer must return to 0.
    do_reset(2, 1'b0);
    done_mode = 2;
    req_data[7:0] = 8'hD0; req_valid[0] = 1'b1;
    wait_sent(sent_q.size() + 1);
    repeat (100) step();
    req_data[7:0] = 8'hE0; req_data[15:8] = 8'hE1; req_valid[1:0] = 2'b11;
    step();
    chk("rb_still_busy", 32'(busy), 32'h1);
    reset = 1'b1; cd = 0; tx_done = 1'b0; acc_pend = '0;
    step();
    chk("rb_busy", 32'(busy), 32'h0);
    chk("rb_tx_data", 32'(tx_data), 32'h0);
    chk("rb_grant_id", 32'(grant_id), 32'h0);
    reset = 1'b0; done_mode = 0;
    base = sent_q.size();
    wait_sent(base + 2);
    wait_idle();
    chk("rb_first", 32'((sent_q.size() > base) ? sent_q[base] : 8'hxx), 32'hE0);
    chk("rb_second", 32'((sent_q.size() > base + 1) ? sent_q[base + 1] : 8'hxx), 32'hE1);

    // Withdrawal of requester 3 in its grant cycle (pointer is 2 here).
    base = sent_q.size();
    withdraw[3] = 1'b1; req_data[31:24] = 8'h99; req_valid[3] = 1'b1;
    repeat (6) step();
    chk("wdr_no_tx", 32'(sent_q.size() - base), 32'h0);
    chk("wdr_tx_data", 32'(tx_data), 32'hE1);
    chk("wdr_busy", 32'(busy), 32'h0);
    chk("wdr_grant_id", 32'(grant_id), 32'h3);
    withdraw = '0;
    req_data[7:0] = 8'hC0; req_data[23:16] = 8'hC2; req_valid = 4'b0101;
    wait_sent(base + 2);
    wait_idle();
    chk("wdr_ptr_first", 32'((sent_q.size() > base) ? sent_q[base] : 8'hxx), 32'hC2);
    chk("wdr_ptr_second", 32'((sent_q.size() > base + 1) ? sent_q[base + 1] : 8'hxx), 32'hC0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, tests=%0d", tests);
    $fatal(1);
  end

endmodule
